// File: rtl/disp_capture_pkg.sv
// rtl/disp_capture_pkg.sv - shared display geometry, defaults and capture FSM encoding
package disp_capture_pkg;

   localparam int DIGITS      = 4;
   localparam int NIB_W       = 4;
   localparam int AN_W        = 4;
   localparam int SETTLE_DEF  = 4;
   localparam int TIMEOUT_DEF = 65535;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } cap_state_t;

endpackage

// File: rtl/disp_capture_an_onehot_decode.sv
// rtl/disp_capture_an_onehot_decode.sv - one-hot digit select to index plus validity flag
module an_onehot_decode
   import disp_capture_pkg::*;
(
   input  logic [AN_W-1:0] an,
   output logic [1:0]      idx,
   output logic            onehot_ok
);

   always_comb begin
      idx       = 2'd0;
      onehot_ok = 1'b0;
      case (an)
         4'b0001: begin idx = 2'd0; onehot_ok = 1'b1; end
         4'b0010: begin idx = 2'd1; onehot_ok = 1'b1; end
         4'b0100: begin idx = 2'd2; onehot_ok = 1'b1; end
         4'b1000: begin idx = 2'd3; onehot_ok = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/disp_capture.sv
// rtl/disp_capture.sv - reconstructs a 4-digit frame from a multiplexed (AN, Hex) display bus
module disp_capture
   import disp_capture_pkg::*;
#(
   parameter int SETTLE  = SETTLE_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [AN_W-1:0]         AN,
   input  logic [NIB_W-1:0]        Hex,
   output logic [DIGITS*NIB_W-1:0] Hexs,
   output logic [1:0]              scan,
   output logic                    frame_valid,
   output logic                    changed,
   output logic                    an_err,
   output logic                    stale
);

   localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   logic [AN_W-1:0]         an_q, cand_an;
   logic [NIB_W-1:0]        hex_q, cand_hex;
   logic                    primed;
   logic [3:0]              cnt, cnt_d;
   cap_state_t              state, state_d;
   logic [DIGITS-1:0]       mask, mask_set;
   logic [DIGITS*NIB_W-1:0] shadow, shadow_new;
   logic [15:0]             idle;
   logic [1:0]              idx;
   logic                    onehot_ok, same, restart, cand_ld, capture, an_err_d;

   an_onehot_decode u_dec (
      .an        (an_q),
      .idx       (idx),
      .onehot_ok (onehot_ok)
   );

   assign same  = (an_q == cand_an) && (hex_q == cand_hex);
   assign stale = (idle == TIMEOUT_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_WAIT;
      else        state <= state_d;
   end

   // The reset value of an_q is not a real bus sample, so the first edge is skipped.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      restart  = 1'b0;
      cand_ld  = 1'b0;
      capture  = 1'b0;
      an_err_d = 1'b0;
      if (primed) begin
         case (state)
            ST_WAIT:   restart = 1'b1;
            ST_SETTLE: begin
               if (!same) begin
                  restart = 1'b1;
               end else if (cnt + 4'd1 == SETTLE_C) begin
                  capture = 1'b1;
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt + 4'd1;
               end
            end
            ST_HELD:   restart = !same;
            default:   state_d = ST_WAIT;
         endcase
      end
      if (restart) begin
         if (onehot_ok) begin
            cnt_d   = 4'd1;
            cand_ld = 1'b1;
            state_d = ST_SETTLE;
         end else begin
            an_err_d = 1'b1;
            state_d  = ST_WAIT;
         end
      end
   end

   always_comb begin
      mask_set   = mask | ({{(DIGITS-1){1'b0}}, 1'b1} << idx);
      shadow_new = shadow;
      shadow_new[{idx, 2'b00} +: NIB_W] = hex_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q        <= '0;
         hex_q       <= '0;
         primed      <= 1'b0;
         cand_an     <= '0;
         cand_hex    <= '0;
         cnt         <= '0;
         mask        <= '0;
         shadow      <= '0;
         Hexs        <= '0;
         scan        <= '0;
         frame_valid <= 1'b0;
         changed     <= 1'b0;
         an_err      <= 1'b0;
         idle        <= '0;
      end else begin
         an_q        <= AN;
         hex_q       <= Hex;
         primed      <= 1'b1;
         cnt         <= cnt_d;
         an_err      <= an_err_d;
         frame_valid <= 1'b0;
         changed     <= 1'b0;
         if (cand_ld) begin
            cand_an  <= an_q;
            cand_hex <= hex_q;
         end
         if (capture) begin
            shadow <= shadow_new;
            scan   <= idx;
            idle   <= '0;
            // Completing the mask publishes the frame and starts collecting the next one.
            if (&mask_set) begin
               Hexs        <= shadow_new;
               frame_valid <= 1'b1;
               changed     <= (shadow_new != Hexs);
               mask        <= '0;
            end else begin
               mask <= mask_set;
            end
         end else if (idle != TIMEOUT_C) begin
            idle <= idle + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_disp_capture.sv
// tb/tb_disp_capture.sv - directed and randomized bench for disp_capture
module tb_disp_capture;

   localparam int S = 4;
   localparam int T = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  AN = 4'h0;
   logic [3:0]  Hex = 4'h0;
   logic [15:0] Hexs;
   logic [1:0]  scan;
   logic        frame_valid, changed, an_err, stale;

   int checks = 0;
   int errors = 0;

   logic [3:0]  m_anq, m_hexq, p_an, p_hex;
   logic [3:0]  m_sh [4];
   logic [3:0]  m_mask;
   logic [15:0] m_hexs;
   logic [1:0]  m_scan;
   logic        m_fv, m_ch, m_err;
   bit          m_primed;
   int          run, m_idle;

   disp_capture #(.SETTLE(S), .TIMEOUT(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .AN          (AN),
      .Hex         (Hex),
      .Hexs        (Hexs),
      .scan        (scan),
      .frame_valid (frame_valid),
      .changed     (changed),
      .an_err      (an_err),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int onehot_index(input logic [3:0] a);
      int k = -1;
      if ($countones(a) == 1)
         for (int i = 0; i < 4; i++) if (a[i]) k = i;
      return k;
   endfunction

   task automatic model_reset();
      m_anq = 0; m_hexq = 0; p_an = 0; p_hex = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 0;
      m_mask = 0; m_hexs = 0; m_scan = 0;
      m_fv = 0; m_ch = 0; m_err = 0;
      m_primed = 0; run = 0; m_idle = 0;
   endtask

   // A digit is taken when a run of identical one-hot samples reaches exactly S long.
   task automatic model_edge();
      int k;
      logic [15:0] nf;
      k = -1;
      m_fv = 0; m_ch = 0; m_err = 0;
      if (m_primed) begin
         if (m_anq == p_an && m_hexq == p_hex) run++;
         else run = 1;
         p_an = m_anq; p_hex = m_hexq;
         k = onehot_index(m_anq);
         m_err = (k < 0);
      end
      if (k >= 0 && run == S) begin
         m_sh[k] = m_hexq;
         m_scan = 2'(k);
         m_mask[k] = 1'b1;
         m_idle = 0;
         if (m_mask == 4'hF) begin
            nf = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            m_ch = (nf != m_hexs);
            m_hexs = nf;
            m_fv = 1;
            m_mask = 0;
         end
      end else if (m_idle < T) begin
         m_idle++;
      end
      m_primed = 1;
      m_anq = AN;
      m_hexq = Hex;
   endtask

   task automatic compare_all();
      chk("hexs", Hexs, m_hexs);
      chk("scan", 16'(scan), 16'(m_scan));
      chk("frame_valid", 16'(frame_valid), 16'(m_fv));
      chk("changed", 16'(changed), 16'(m_ch));
      chk("an_err", 16'(an_err), 16'(m_err));
      chk("stale", 16'(stale), 16'(m_idle == T));
   endtask

   task automatic step(input logic [3:0] a, input logic [3:0] h);
      AN = a; Hex = h;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic hold(input logic [3:0] a, input logic [3:0] h, input int n);
      for (int i = 0; i < n; i++) step(a, h);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("rst_hexs", Hexs, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] a, h;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         step(4'b0001, 4'hA);
         chk("single_an_err", 16'(an_err), 16'h0);
         chk("single_fv", 16'(frame_valid), 16'h0);
      end

      for (int r = 0; r < 2; r++) begin
         hold(4'b0100, 4'h2, 5);
         hold(4'b0001, 4'h4, 5);
         hold(4'b1000, 4'h1, 5);
         hold(4'b0010, 4'h3, 5);
         chk("frame_fv", 16'(frame_valid), 16'h1);
         chk("frame_hexs", Hexs, 16'h1234);
         chk("frame_changed", 16'(changed), 16'(r == 0));
      end

      step(4'b0000, 4'h0);
      step(4'b0110, 4'h0);
      chk("err_zero_an", 16'(an_err), 16'h1);
      step(4'b0001, 4'h4);
      chk("err_multi_an", 16'(an_err), 16'h1);
      chk("err_hexs_kept", Hexs, 16'h1234);
      step(4'b0001, 4'h4);
      chk("err_cleared", 16'(an_err), 16'h0);

      for (int i = 0; i < 3; i++) begin
         hold(4'b0100, 4'h6, 2);
         hold(4'b0100, 4'h5, 2);
      end
      chk("toggle_no_capture", 16'(scan), 16'h1);
      hold(4'b0100, 4'h6, 5);
      chk("toggle_settled", 16'(scan), 16'h2);
      hold(4'b0001, 4'h4, 5);
      hold(4'b0010, 4'h1, 5);
      hold(4'b1000, 4'h1, 5);
      chk("toggle_frame_fv", 16'(frame_valid), 16'h1);
      chk("toggle_frame_hexs", Hexs, 16'h1614);

      do_reset();
      for (int i = 1; i <= 28; i++) begin
         step(4'b0000, 4'h0);
         chk("stale_level", 16'(stale), 16'(i >= T));
      end
      for (int i = 1; i <= 5; i++) begin
         step(4'b0001, 4'h7);
         chk("stale_release", 16'(stale), 16'(i < 5));
      end

      hold(4'b0010, 4'h8, 5);
      hold(4'b0100, 4'h9, 5);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(4'b1000, 4'h5);
         chk("post_reset_no_frame", 16'(frame_valid), 16'h0);
      end

      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 3) == 0) a = 4'($urandom);
         else a = 4'b0001 << $urandom_range(0, 3);
         h = 4'($urandom_range(0, 3));
         hold(a, h, $urandom_range(1, 7));
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
